// File: rtl/bit_stream_writer_if.sv
// Bit-write bus between byte-level control logic and the bit_stream_writer.
//
// Signals
//   data_in    byte to serialize, sampled when a request is accepted
//   start      request strobe; accepted when start & ready at a clock edge
//   ready      writer idle and able to accept a request
//   bit_index  index of the bit currently presented
//   bit_value  value of the latched byte at bit_index
//   valid_out  write strobe toward the display register block
//   busy       transfer in progress (always the inverse of ready)
//   done       one-cycle pulse after the final bit
//
// Modports
//   master  request side (drives data_in/start, observes the rest)
//   slave   the writer itself
interface bit_stream_writer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
);

  logic [DATA_W-1:0] data_in;
  logic              start;
  logic              ready;
  logic [IDX_W-1:0]  bit_index;
  logic              bit_value;
  logic              valid_out;
  logic              busy;
  logic              done;

  modport master (
    output data_in,
    output start,
    input  ready,
    input  bit_index,
    input  bit_value,
    input  valid_out,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  start,
    output ready,
    output bit_index,
    output bit_value,
    output valid_out,
    output busy,
    output done
  );

endinterface

// File: rtl/bit_stream_writer.sv
// Byte-to-bit serializer for the indexed bit-write port of the display
// register block. A byte accepted on the start/ready handshake is replayed
// as DATA_W (bit_index, bit_value, valid_out) writes, each held for
// HOLD_CYCLES clocks, optionally separated by GAP_CYCLES idle clocks, and
// followed by a one-cycle done pulse.
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    bit_stream_writer_if.slave (data_in, start, ready, bit_index,
//          bit_value, valid_out, busy, done)
//
// Parameters
//   DATA_W       bits per transfer
//   HOLD_CYCLES  clocks each bit is strobed (>= 1)
//   GAP_CYCLES   idle clocks between consecutive bits (0 = back to back)
//   LSB_FIRST    1: index 0 upward; 0: index DATA_W-1 downward
module bit_stream_writer #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 5,
  parameter int GAP_CYCLES  = 0,
  parameter int LSB_FIRST   = 1
) (
  input  logic               clk,
  input  logic               reset,
  bit_stream_writer_if.slave bus
);

  localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

  localparam logic [IDX_W-1:0] FIRST_IDX = (LSB_FIRST != 0) ? IDX_W'(0) : IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = (LSB_FIRST != 0) ? IDX_W'(DATA_W - 1) : IDX_W'(0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_next;

  // Walk direction is fixed by LSB_FIRST; the last index is caught before
  // stepping, so the index never wraps.
  assign idx_next = (LSB_FIRST != 0) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // ready is high only here, so start & ready reduces to start.
        if (bus.start) begin
          data_d  = bus.data_in;
          idx_d   = FIRST_IDX;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else if (GAP_CYCLES > 0) begin
            // Index advances on leaving the gap, so the gap keeps
            // presenting the bit just written.
            state_d = GAP;
          end else begin
            idx_d = idx_next;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_next;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode straight from registers, so an asynchronous reset
  // clears them immediately.
  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.valid_out = (state_q == SEND);
  assign bus.done      = (state_q == DONE);
  assign bus.bit_index = idx_q;
  assign bus.bit_value = data_q[idx_q];

endmodule

// File: tb/tb_bit_stream_writer.sv
module tb_bit_stream_writer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  bit_stream_writer_if #(.DATA_W(8)) if0 ();
  bit_stream_writer_if #(.DATA_W(8)) if1 ();

  bit_stream_writer #(.DATA_W(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  bit_stream_writer #(.DATA_W(8), .HOLD_CYCLES(1), .GAP_CYCLES(2), .LSB_FIRST(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: per writer, mk = cycles since acceptance
  // (1 = first cycle after the accepting edge), 0 = idle.
  int       ph[2]    = '{5, 1};
  int       pg[2]    = '{0, 2};
  bit       plsb[2]  = '{1'b1, 1'b0};
  int       mk[2]    = '{0, 0};
  logic [7:0] md[2]  = '{8'h00, 8'h00};
  bit       mhave[2] = '{1'b0, 1'b0};

  function automatic int tlen(input int d);
    return 8 * ph[d] + 7 * pg[d];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_out(input int d, output bit er, output bit ev, output bit edn,
                            output int ei, output bit eb);
    int k, t, last, p, b, r;
    k    = mk[d];
    t    = tlen(d);
    last = plsb[d] ? 7 : 0;
    er = 1'b0; ev = 1'b0; edn = 1'b0; ei = 0; eb = 1'b0;
    if (k == 0) begin
      er = 1'b1;
      ei = mhave[d] ? last : 0;
      eb = mhave[d] ? md[d][ei] : 1'b0;
    end else if (k <= t) begin
      p  = k - 1;
      b  = p / (ph[d] + pg[d]);
      r  = p % (ph[d] + pg[d]);
      ev = (r < ph[d]);
      ei = plsb[d] ? b : 7 - b;
      eb = md[d][ei];
    end else begin
      edn = 1'b1;
      ei  = last;
      eb  = md[d][ei];
    end
  endtask

  task automatic compare_dut(input int d);
    bit er, ev, edn, eb;
    int ei;
    logic ar, ab, av, adn, abv;
    int ai;
    expect_out(d, er, ev, edn, ei, eb);
    if (d == 0) begin
      ar = if0.ready; ab = if0.busy; av = if0.valid_out; adn = if0.done;
      abv = if0.bit_value; ai = int'(if0.bit_index);
    end else begin
      ar = if1.ready; ab = if1.busy; av = if1.valid_out; adn = if1.done;
      abv = if1.bit_value; ai = int'(if1.bit_index);
    end
    chk($sformatf("dut%0d ready", d), int'(ar), int'(er));
    chk($sformatf("dut%0d busy", d), int'(ab), int'(!er));
    chk($sformatf("dut%0d valid_out", d), int'(av), int'(ev));
    chk($sformatf("dut%0d done", d), int'(adn), int'(edn));
    chk($sformatf("dut%0d bit_index", d), ai, ei);
    chk($sformatf("dut%0d bit_value", d), int'(abv), int'(eb));
  endtask

  always @(negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      mk[d] = 0; md[d] = 8'h00; mhave[d] = 1'b0;
    end
  end

  always @(posedge clk) begin : model_step
    logic       s;
    logic [7:0] din;
    for (int d = 0; d < 2; d++) begin
      s   = (d == 0) ? if0.start : if1.start;
      din = (d == 0) ? if0.data_in : if1.data_in;
      if (!reset) begin
        mk[d] = 0; md[d] = 8'h00; mhave[d] = 1'b0;
      end else if (mk[d] == 0) begin
        if (s) begin
          mk[d] = 1;
          md[d] = din;
        end
      end else begin
        mk[d]++;
        if (mk[d] == tlen(d) + 2) begin
          mk[d]    = 0;
          mhave[d] = 1'b1;
        end
      end
    end
    #2;
    compare_dut(0);
    compare_dut(1);
  end

  // Called 1 time unit after an accepting edge; k = 1 is the cycle right
  // after that edge.
  task automatic collect(input int d, input int n, input int stride, input bit inject,
                         output int vcount, output int dcount, output int done_at,
                         output int ready_at, output logic [7:0] vals,
                         output logic [7:0][2:0] idxs, output logic [63:0] vpat);
    logic v, dn, r, bv;
    logic [2:0] bi;
    vcount = 0; dcount = 0; done_at = -1; ready_at = -1;
    vals = '0; idxs = '0; vpat = '0;
    for (int k = 1; k <= n; k++) begin
      if (k == 1) #1;
      else begin
        @(posedge clk);
        #2;
      end
      if (d == 0) begin
        v = if0.valid_out; dn = if0.done; r = if0.ready; bv = if0.bit_value; bi = if0.bit_index;
      end else begin
        v = if1.valid_out; dn = if1.done; r = if1.ready; bv = if1.bit_value; bi = if1.bit_index;
      end
      if (v) begin
        vcount++;
        if (k <= 64) vpat[k-1] = 1'b1;
      end
      if (dn) begin
        dcount++;
        if (done_at < 0) done_at = k;
      end
      if (r && ready_at < 0) ready_at = k;
      for (int i = 0; i < 8; i++) begin
        if (k == 1 + stride * i) begin
          vals[i] = bv;
          idxs[i] = bi;
        end
      end
      if (inject && d == 0) begin
        if (k == 10) begin if0.start = 1'b1; if0.data_in = 8'hFF; end
        if (k == 20) begin if0.start = 1'b0; if0.data_in = 8'h00; end
      end
    end
  endtask

  initial begin : stim
    int vc, dc, da, ra, cnt;
    bit saw_idle;
    logic [7:0] vals;
    logic [7:0][2:0] idxs;
    logic [63:0] vpat;

    if0.start = 1'b0; if0.data_in = 8'h00;
    if1.start = 1'b0; if1.data_in = 8'h00;
    #1 reset = 1'b0;

    // Start toggled while held in reset: no acceptance.
    if0.data_in = 8'h33;
    repeat (4) begin
      @(negedge clk);
      if0.start = ~if0.start;
    end
    @(negedge clk);
    if0.start = 1'b0;
    #1;
    chk("rst ready", int'(if0.ready), 1);
    chk("rst valid_out", int'(if0.valid_out), 0);
    chk("rst done", int'(if0.done), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("post-rst ready", int'(if0.ready), 1);

    // 8'hA5 with a start/FF attempt mid-transfer.
    @(negedge clk);
    if0.data_in = 8'hA5; if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0; if0.data_in = 8'h00;
    collect(0, 42, 5, 1'b1, vc, dc, da, ra, vals, idxs, vpat);
    chk("A5 valid count", vc, 40);
    chk("A5 valid pattern lo", int'(vpat[31:0]), int'(32'hFFFF_FFFF));
    chk("A5 valid pattern hi", int'(vpat[63:32]), int'(32'h0000_00FF));
    chk("A5 done at", da, 41);
    chk("A5 done count", dc, 1);
    chk("A5 ready back at", ra, 42);
    chk("A5 bit values", int'(vals), int'(8'hA5));
    for (int i = 0; i < 8; i++) chk($sformatf("A5 index slot %0d", i), int'(idxs[i]), i);

    // Reset during bit 3, then 8'h0F from a clean start.
    @(negedge clk);
    if0.data_in = 8'h3C; if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    chk("mid bit_index", int'(if0.bit_index), 3);
    chk("mid valid_out", int'(if0.valid_out), 1);
    #1 reset = 1'b0;
    #1;
    chk("async valid_out", int'(if0.valid_out), 0);
    chk("async busy", int'(if0.busy), 0);
    chk("async ready", int'(if0.ready), 1);
    chk("async done", int'(if0.done), 0);
    chk("async bit_index", int'(if0.bit_index), 0);
    chk("async bit_value", int'(if0.bit_value), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if0.data_in = 8'h0F; if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    collect(0, 42, 5, 1'b0, vc, dc, da, ra, vals, idxs, vpat);
    chk("0F bit values", int'(vals), int'(8'h0F));
    chk("0F first index", int'(idxs[0]), 0);
    chk("0F done at", da, 41);
    chk("0F done count", dc, 1);

    // start held high across two transfers.
    @(negedge clk);
    if0.data_in = 8'h01; if0.start = 1'b1;
    @(posedge clk); #1;
    if0.data_in = 8'h80;
    cnt = 0; saw_idle = 1'b0;
    while (cnt < 100) begin
      @(posedge clk); #2;
      cnt++;
      if (if0.ready) saw_idle = 1'b1;
      else if (saw_idle) break;
    end
    chk("back-to-back accept spacing", cnt, 42);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (45) @(posedge clk);
    #2;
    chk("80 idle bit_index", int'(if0.bit_index), 7);
    chk("80 idle bit_value", int'(if0.bit_value), 1);
    chk("80 idle ready", int'(if0.ready), 1);

    // MSB-first writer with gaps.
    @(negedge clk);
    if1.data_in = 8'h80; if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    collect(1, 25, 3, 1'b0, vc, dc, da, ra, vals, idxs, vpat);
    chk("gap first index", int'(idxs[0]), 7);
    chk("gap first value", int'(vals[0]), 1);
    chk("gap bit values", int'(vals), int'(8'h01));
    chk("gap valid pattern", int'(vpat[31:0]), int'(32'h0024_9249));
    chk("gap valid count", vc, 8);
    chk("gap done at", da, 23);
    chk("gap ready back at", ra, 24);
    for (int i = 0; i < 8; i++) chk($sformatf("gap index slot %0d", i), int'(idxs[i]), 7 - i);

    // Random traffic on both writers with one reset pulse.
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if (it == 200) reset = 1'b0;
      if (it == 202) reset = 1'b1;
      if0.start   = ($urandom_range(0, 3) == 0);
      if0.data_in = 8'($urandom);
      if1.start   = ($urandom_range(0, 3) == 0);
      if1.data_in = 8'($urandom);
    end
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    repeat (60) @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
